fallthrough_small_fifo: RTL and testbench

Small synchronous first-word-fall-through (FWFT) FIFO with a parameterised word width and a power-of-two depth. The head entry is always presented on dout while the FIFO is non-empty, and rd_en acts as an acknowledge/pop. It is used as the ingress buffer of stream-processing pcores (e.g. the output-port-lookup stage), which pack {tlast, tuser, tstrb, tdata} into one word. nearly_full provides one entry of slack to drive upstream TREADY.

---
 rtl/fallthrough_small_fifo.sv | 69 ++++++
 tb/tb_fallthrough_small_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - first-word-fall-through FIFO with power-of-two depth
module fallthrough_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] C_NEARLY  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS:0] C_PROG    = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wptr;
    logic [MAX_DEPTH_BITS-1:0] r_rptr;
    logic [MAX_DEPTH_BITS:0]   r_count;

    logic w_wr_ok;
    logic w_rd_ok;

    // Flags come only from the registered count so upstream ready has no path from wr_en/rd_en.
    assign empty       = (r_count == '0);
    assign full        = (r_count == C_DEPTH);
    assign nearly_full = (r_count >= C_NEARLY);
    assign prog_full   = (r_count >= C_PROG);

    assign w_wr_ok = wr_en & ~full;
    assign w_rd_ok = rd_en & ~empty;

    assign dout = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// tb/tb_fallthrough_small_fifo.sv - table-driven bench for fallthrough_small_fifo
module tb_fallthrough_small_fifo;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         prog_full;
    logic         empty;

    always #5 clk = ~clk;

    fallthrough_small_fifo #(
        .WIDTH          (W),
        .MAX_DEPTH_BITS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
        .prog_full   (prog_full),
        .empty       (empty)
    );

    // flags = {empty, full, nearly_full, prog_full} expected after the edge
    typedef struct {
        logic         rst_n;
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic [3:0]   flags;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [3:0] F0 = 4'b1000;
    localparam logic [3:0] F1 = 4'b0000;
    localparam logic [3:0] F2 = 4'b0000;
    localparam logic [3:0] F3 = 4'b0011;
    localparam logic [3:0] F4 = 4'b0111;

    function automatic void add(input logic r, input logic w, input logic rd,
                                input logic [W-1:0] d, input logic [3:0] f,
                                input logic [W-1:0] q);
        vec_t v;
        v.rst_n = r; v.wr = w; v.rd = rd; v.din = d; v.flags = f; v.dout = q;
        vecs.push_back(v);
    endfunction

    task automatic check_flags(input int idx, input logic [3:0] exp);
        logic [3:0] act;
        act = {empty, full, nearly_full, prog_full};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL flags vec %0d: got {e,f,nf,pf}=%b expected %b", idx, act, exp);
        end
    endtask

    task automatic check_dout(input int idx, input logic [W-1:0] exp);
        n_tests++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL dout vec %0d: got %h expected %h", idx, dout, exp);
        end
    endtask

    initial begin
        reset = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;

        // reset held with write active
        add(0, 1, 0, 8'h55, F0, 8'h00);
        add(0, 1, 0, 8'h66, F0, 8'h00);
        // fill, fall-through, flag thresholds
        add(1, 1, 0, 8'hA1, F1, 8'hA1);
        add(1, 1, 0, 8'hA2, F2, 8'hA1);
        add(1, 1, 0, 8'hA3, F3, 8'hA1);
        add(1, 1, 0, 8'hA4, F4, 8'hA1);
        add(1, 1, 0, 8'hFF, F4, 8'hA1);
        // drain
        add(1, 0, 1, 8'h00, F3, 8'hA2);
        add(1, 0, 1, 8'h00, F2, 8'hA3);
        add(1, 0, 1, 8'h00, F1, 8'hA4);
        add(1, 0, 1, 8'h00, F0, 8'h00);
        // steady count 2 with simultaneous read/write across wrap
        add(1, 1, 0, 8'hB0, F1, 8'hB0);
        add(1, 1, 0, 8'hB1, F2, 8'hB0);
        for (int k = 0; k < 6; k++)
            add(1, 1, 1, 8'hB2 + 8'(k), F2, 8'hB1 + 8'(k));
        add(1, 0, 1, 8'h00, F1, 8'hB7);
        add(1, 0, 1, 8'h00, F0, 8'h00);
        // read while empty is ignored
        add(1, 0, 1, 8'h00, F0, 8'h00);
        add(1, 1, 0, 8'hC5, F1, 8'hC5);
        add(1, 0, 1, 8'h00, F0, 8'h00);
        // full with simultaneous read/write: read wins, write dropped
        add(1, 1, 0, 8'hD1, F1, 8'hD1);
        add(1, 1, 0, 8'hD2, F2, 8'hD1);
        add(1, 1, 0, 8'hD3, F3, 8'hD1);
        add(1, 1, 0, 8'hD4, F4, 8'hD1);
        add(1, 1, 1, 8'hEE, F3, 8'hD2);
        add(1, 0, 1, 8'h00, F2, 8'hD3);
        add(1, 0, 1, 8'h00, F1, 8'hD4);
        add(1, 0, 1, 8'h00, F0, 8'h00);
        // empty with simultaneous read/write: write wins
        add(1, 1, 1, 8'hE1, F1, 8'hE1);
        add(1, 1, 0, 8'hE2, F2, 8'hE1);
        // reset mid-stream discards contents
        add(0, 0, 0, 8'h00, F0, 8'h00);
        add(1, 1, 0, 8'hF1, F1, 8'hF1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst_n;
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            din   = vecs[i].din;
            @(posedge clk);
            #1;
            check_flags(i, vecs[i].flags);
            if (!vecs[i].flags[3])
                check_dout(i, vecs[i].dout);
        end

        // flags must not react to wr_en/rd_en before the edge
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_en = 1'b1; din = 8'hF2 + 8'(k);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        check_flags(100, F3);
        wr_en = 1'b1; din = 8'h99;
        #2;
        check_flags(101, F3);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check_flags(102, F4);
        rd_en = 1'b1;
        #2;
        check_flags(103, F4);
        check_dout(103, 8'hF1);
        @(posedge clk); #1;
        rd_en = 1'b0;
        check_flags(104, F3);
        check_dout(104, 8'hF2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
